// File: rtl/fifo_pkg.sv
// fifo_pkg: helpers shared by the write- and read-side pointer controllers
// of the asynchronous FIFO.
//   bin2gray : binary -> reflected Gray code
//   gray2bin : reflected Gray code -> binary
// Both work on a fixed wide vector. Callers zero-extend their pointer into it
// and truncate the result, which is exact because leading zeros map to
// leading zeros in both directions.
package fifo_pkg;

   localparam int unsigned FIFO_CODE_W = 32;

   typedef logic [FIFO_CODE_W-1:0] fifo_code_t;

   function automatic fifo_code_t bin2gray(input fifo_code_t bin);
      return bin ^ (bin >> 1);
   endfunction

   function automatic fifo_code_t gray2bin(input fifo_code_t gray);
      fifo_code_t bin;
      bin = '0;
      bin[FIFO_CODE_W-1] = gray[FIFO_CODE_W-1];
      for (int unsigned i = 0; i < FIFO_CODE_W - 1; i++) begin
         bin[FIFO_CODE_W-2-i] = bin[FIFO_CODE_W-1-i] ^ gray[FIFO_CODE_W-2-i];
      end
      return bin;
   endfunction

endpackage

// File: rtl/nff_synchronizer.sv
// nff_synchronizer: STAGES-deep flop chain that brings a multi-bit value
// (expected to be Gray coded, so at most one bit changes at a time) into the
// clk domain.
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, clears every stage to 0
//   d     - asynchronous input
//   q     - synchronised output (last stage)
module nff_synchronizer #(
   parameter int unsigned WIDTH  = 1,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] sync_q [STAGES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= d;
         for (int unsigned i = 1; i < STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/w_ptr_full_ctrl.sv
// w_ptr_full_ctrl: write-side pointer and status controller of the async FIFO.
// Runs entirely in the w_clk domain.
//   w_clk         - write clock
//   wrst_n        - asynchronous active-low reset
//   w_en          - write request
//   r_ptr         - Gray read pointer from the read domain (asynchronous)
//   w_ptr         - registered Gray write pointer, to the read domain
//   w_addr        - binary memory write address
//   w_full        - registered full flag
//   w_almost_full - registered flag, level >= AFULL_THRESH
//   w_level       - registered write-side occupancy, 0..DEPTH
//   w_overflow    - sticky, set by a write attempt while full
// Status uses a synchronised (stale) read pointer, so it can over-report
// occupancy but never under-report it.
module w_ptr_full_ctrl
   import fifo_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = 4,
   parameter int unsigned SYNC_STAGES  = 2,
   parameter int unsigned AFULL_THRESH = (1 << ADDR_WIDTH) - 2
) (
   input  logic                  w_clk,
   input  logic                  wrst_n,
   input  logic                  w_en,
   input  logic [ADDR_WIDTH:0]   r_ptr,
   output logic [ADDR_WIDTH:0]   w_ptr,
   output logic [ADDR_WIDTH-1:0] w_addr,
   output logic                  w_full,
   output logic                  w_almost_full,
   output logic [ADDR_WIDTH:0]   w_level,
   output logic                  w_overflow
);

   localparam int unsigned PW = ADDR_WIDTH + 1;

   // Full when the next Gray write pointer equals the synchronised read
   // pointer with its two MSBs inverted; XOR with this mask does the inversion.
   localparam logic [ADDR_WIDTH:0] FULL_MASK   = PW'(3) << (ADDR_WIDTH - 1);
   localparam logic [ADDR_WIDTH:0] AFULL_LEVEL = PW'(AFULL_THRESH);

   logic [ADDR_WIDTH:0] w_bin;
   logic [ADDR_WIDTH:0] w_bnext;
   logic [ADDR_WIDTH:0] w_gnext;
   logic [ADDR_WIDTH:0] wq_rptr;
   logic [ADDR_WIDTH:0] wq_rbin;
   logic [ADDR_WIDTH:0] level_next;
   logic                accept;
   logic                full_next;
   logic                afull_next;

   nff_synchronizer #(
      .WIDTH  (PW),
      .STAGES (SYNC_STAGES)
   ) u_rptr_sync (
      .clk   (w_clk),
      .rst_n (wrst_n),
      .d     (r_ptr),
      .q     (wq_rptr)
   );

   always_comb begin
      accept     = w_en & ~w_full;
      w_bnext    = w_bin + PW'(accept);
      w_gnext    = PW'(bin2gray(FIFO_CODE_W'(w_bnext)));
      wq_rbin    = PW'(gray2bin(FIFO_CODE_W'(wq_rptr)));
      // Modulo 2^(ADDR_WIDTH+1) subtraction stays correct across pointer wrap.
      level_next = w_bnext - wq_rbin;
      full_next  = (w_gnext == (wq_rptr ^ FULL_MASK));
      afull_next = (level_next >= AFULL_LEVEL);
   end

   always_ff @(posedge w_clk or negedge wrst_n) begin
      if (!wrst_n) begin
         w_bin         <= '0;
         w_ptr         <= '0;
         w_full        <= 1'b0;
         w_almost_full <= 1'b0;
         w_level       <= '0;
         w_overflow    <= 1'b0;
      end else begin
         w_bin         <= w_bnext;
         w_ptr         <= w_gnext;
         w_full        <= full_next;
         w_almost_full <= afull_next;
         w_level       <= level_next;
         w_overflow    <= w_overflow | (w_en & w_full);
      end
   end

   assign w_addr = w_bin[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_w_ptr_full_ctrl.sv
module tb_w_ptr_full_ctrl;

   localparam int AW    = 3;
   localparam int SS    = 2;
   localparam int AT    = 6;
   localparam int DEPTH = 1 << AW;
   localparam int PMOD  = 2 * DEPTH;

   logic          w_clk;
   logic          wrst_n;
   logic          w_en;
   logic [AW:0]   r_ptr;
   logic [AW:0]   w_ptr;
   logic [AW-1:0] w_addr;
   logic          w_full;
   logic          w_almost_full;
   logic [AW:0]   w_level;
   logic          w_overflow;

   w_ptr_full_ctrl #(
      .ADDR_WIDTH   (AW),
      .SYNC_STAGES  (SS),
      .AFULL_THRESH (AT)
   ) dut (
      .w_clk         (w_clk),
      .wrst_n        (wrst_n),
      .w_en          (w_en),
      .r_ptr         (r_ptr),
      .w_ptr         (w_ptr),
      .w_addr        (w_addr),
      .w_full        (w_full),
      .w_almost_full (w_almost_full),
      .w_level       (w_level),
      .w_overflow    (w_overflow)
   );

   initial w_clk = 1'b0;
   always #5 w_clk = ~w_clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: unbounded counts of writes accepted and reads done;
   // the read count reaches the write side after SS clock edges.
   int wtot, rtot;
   int sync_q[$];
   int m_level;
   bit m_full, m_af, m_ovf;

   function automatic int gray(input int b);
      return b ^ (b >> 1);
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      wtot = 0; rtot = 0;
      sync_q.delete();
      for (int i = 0; i < SS; i++) sync_q.push_back(0);
      m_level = 0; m_full = 0; m_af = 0; m_ovf = 0;
   endtask

   task automatic model_edge(input bit en);
      int rq;
      rq = sync_q.pop_front();
      sync_q.push_back(rtot);
      if (en && m_full) m_ovf = 1;
      if (en && !m_full) wtot++;
      m_level = wtot - rq;
      m_full  = (m_level == DEPTH);
      m_af    = (m_level >= AT);
   endtask

   task automatic check_model(input string tag);
      check({tag, ".w_ptr"},   int'(w_ptr),         gray(wtot % PMOD));
      check({tag, ".w_addr"},  int'(w_addr),        wtot % DEPTH);
      check({tag, ".w_level"}, int'(w_level),       m_level);
      check({tag, ".w_full"},  int'(w_full),        int'(m_full));
      check({tag, ".w_af"},    int'(w_almost_full), int'(m_af));
      check({tag, ".w_ovf"},   int'(w_overflow),    int'(m_ovf));
   endtask

   // Drive inputs away from the edge, clock once, check 1 time unit later.
   task automatic step(input bit en, input string tag);
      w_en  = en;
      r_ptr = (AW+1)'(gray(rtot % PMOD));
      @(posedge w_clk);
      model_edge(en);
      #1;
      check_model(tag);
   endtask

   typedef struct {
      bit en;
      int exp_ptr;
      int exp_addr;
      bit exp_af;
      bit exp_full;
      int exp_level;
   } vec_t;

   vec_t fill_tab[8];

   initial begin
      int adv;
      fill_tab[0] = '{1,  1, 1, 0, 0, 1};
      fill_tab[1] = '{1,  3, 2, 0, 0, 2};
      fill_tab[2] = '{1,  2, 3, 0, 0, 3};
      fill_tab[3] = '{1,  6, 4, 0, 0, 4};
      fill_tab[4] = '{1,  7, 5, 0, 0, 5};
      fill_tab[5] = '{1,  5, 6, 1, 0, 6};
      fill_tab[6] = '{1,  4, 7, 1, 0, 7};
      fill_tab[7] = '{1, 12, 0, 1, 1, 8};

      // Reset state
      w_en = 0; r_ptr = '0; wrst_n = 0;
      model_reset();
      #1;
      check_model("reset");
      @(negedge w_clk); @(negedge w_clk);
      wrst_n = 1;

      // Scenario 1: fill from empty, table driven
      for (int i = 0; i < 8; i++) begin
         check("fill.addr_before", int'(w_addr), i);
         step(fill_tab[i].en, "fill");
         check("fill.tab_ptr",   int'(w_ptr),         fill_tab[i].exp_ptr);
         check("fill.tab_addr",  int'(w_addr),        fill_tab[i].exp_addr);
         check("fill.tab_af",    int'(w_almost_full), int'(fill_tab[i].exp_af));
         check("fill.tab_full",  int'(w_full),        int'(fill_tab[i].exp_full));
         check("fill.tab_level", int'(w_level),       fill_tab[i].exp_level);
      end

      // Scenario 2: write while full
      for (int i = 0; i < 3; i++) begin
         step(1, "ovf");
         check("ovf.ptr",   int'(w_ptr), 12);
         check("ovf.addr",  int'(w_addr), 0);
         check("ovf.level", int'(w_level), 8);
         check("ovf.flag",  int'(w_overflow), 1);
      end

      // Scenario 3: drain visible exactly SS+1 edges after r_ptr moves
      rtot = 3;
      step(0, "drain");
      check("drain.full_e1",  int'(w_full), 1);
      check("drain.level_e1", int'(w_level), 8);
      step(0, "drain");
      check("drain.full_e2",  int'(w_full), 1);
      check("drain.level_e2", int'(w_level), 8);
      step(0, "drain");
      check("drain.full_e3",  int'(w_full), 0);
      check("drain.level_e3", int'(w_level), 5);
      check("drain.af_e3",    int'(w_almost_full), 0);

      // Scenario 4: wrap to 16 accepted writes with r_ptr = 12 (binary 8)
      rtot = 8;
      for (int i = 0; i < 3; i++) step(0, "wrap_sync");
      for (int i = 0; i < 8; i++) begin
         if (i == 7) check("wrap.ptr_before", int'(w_ptr), 8);
         step(1, "wrap");
      end
      check("wrap.ptr",   int'(w_ptr), 0);
      check("wrap.full",  int'(w_full), 1);
      check("wrap.level", int'(w_level), 8);

      // Scenario 5: write on the edge a 2-step read advance arrives, level 7
      rtot = 9;
      for (int i = 0; i < 3; i++) step(0, "simul_pre");
      check("simul.level7", int'(w_level), 7);
      rtot = 11;
      step(0, "simul");
      step(0, "simul");
      check("simul.level_hold", int'(w_level), 7);
      step(1, "simul");
      check("simul.level", int'(w_level), 6);
      check("simul.af",    int'(w_almost_full), 1);

      // Randomised traffic against the model
      for (int i = 0; i < 400; i++) begin
         adv = wtot - rtot;
         if (adv > 2) adv = 2;
         rtot += $urandom_range(0, adv);
         step(($urandom % 4) != 0, "rand");
      end

      // Scenario 6: asynchronous reset mid-fill
      wrst_n = 0;
      model_reset();
      #1;
      wrst_n = 1;
      @(negedge w_clk);
      for (int i = 0; i < 3; i++) step(1, "rst_fill");
      #1;
      wrst_n = 0;
      r_ptr  = '0;
      model_reset();
      #1;
      check_model("rst_async");
      @(posedge w_clk);
      @(negedge w_clk);
      wrst_n = 1;
      check("rst.addr_first", int'(w_addr), 0);
      step(1, "rst_after");
      check("rst.addr_next", int'(w_addr), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
